// File: rtl/mcpu_periph_fabric.sv
// Peripheral fabric between the DL1C peripheral port and NSLV memory-mapped slaves.
// It pipelines requests one stage to the slaves, returns read data two cycles later, and hosts an interrupt controller.
module mcpu_periph_fabric #(
    parameter int NSLV      = 4,
    parameter int SEL_W     = 4,
    parameter int SLOT_BITS = 12,
    parameter int NIRQ      = 8
) (
    input  logic                   clkrst_core_clk,
    input  logic                   clkrst_core_rst,
    input  logic [29:0]            dl1c2periph_addr,
    input  logic [31:0]            dl1c2periph_data_out,
    input  logic                   dl1c2periph_re,
    input  logic [3:0]             dl1c2periph_we,
    output logic [31:0]            dl1c2periph_data_in,
    output logic [NSLV-1:0]        slv_sel,
    output logic [SLOT_BITS-3:0]   slv_addr,
    output logic [31:0]            slv_wdata,
    output logic [3:0]             slv_we,
    output logic                   slv_re,
    input  logic [NSLV*32-1:0]     slv_rdata,
    input  logic [NIRQ-1:0]        irq_src,
    output logic                   int_pending,
    output logic [3:0]             int_type,
    input  logic                   int_clear
);

    localparam int OFF_W = SLOT_BITS - 2;
    localparam logic [SEL_W-1:0] IC_SLOT   = '1;
    localparam logic [OFF_W-1:0] OFF_PEND  = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_EN    = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_MODE  = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_RAW   = OFF_W'(3);
    localparam logic [OFF_W-1:0] OFF_UCNT  = OFF_W'(4);

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_ACK} irq_state_t;

    logic             c0_wr, c0_rd, c0_mapped;
    logic [SEL_W-1:0] c0_slot;
    logic [OFF_W-1:0] c0_off;

    logic             c1_wr, c1_rd, c1_mapped, c1_is_ic, c1_unmapped;
    logic [SEL_W-1:0] c1_slot;
    logic [OFF_W-1:0] c1_off;
    logic [31:0]      c1_wdata;
    logic [3:0]       c1_we;

    logic [31:0]      byte_mask, ic_rdata, slave_rdata;
    logic [NIRQ-1:0]  wmask, wbits;
    logic             ic_wr, wr_pend, wr_en, wr_mode, wr_ucnt;

    logic [NIRQ-1:0]  enable_r, mode_r, pend_r, irq_q, pend;
    logic [NIRQ-1:0]  edge_set, w1c, ack_clr, req;
    logic [15:0]      ucnt;
    logic [3:0]       lowest, type_next;
    irq_state_t       state, state_next;

    logic             unused_bits;

    assign c0_wr     = |dl1c2periph_we;
    assign c0_rd     = dl1c2periph_re & ~c0_wr;
    assign c0_slot   = dl1c2periph_addr[SLOT_BITS-2 +: SEL_W];
    assign c0_off    = dl1c2periph_addr[OFF_W-1:0];
    assign c0_mapped = 32'(c0_slot) < NSLV;

    // Request stage: slave strobes exist for one cycle and only for mapped slots.
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            c1_rd     <= 1'b0;
            c1_wr     <= 1'b0;
            c1_slot   <= '0;
            c1_off    <= '0;
            c1_wdata  <= '0;
            c1_we     <= '0;
            slv_sel   <= '0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_we    <= '0;
            slv_re    <= 1'b0;
        end else begin
            c1_rd    <= c0_rd;
            c1_wr    <= c0_wr;
            c1_slot  <= c0_slot;
            c1_off   <= c0_off;
            c1_wdata <= dl1c2periph_data_out;
            c1_we    <= dl1c2periph_we;
            if ((c0_rd || c0_wr) && c0_mapped) begin
                slv_sel   <= NSLV'(1) << c0_slot;
                slv_addr  <= c0_off;
                slv_wdata <= c0_wr ? dl1c2periph_data_out : 32'h0;
                slv_we    <= dl1c2periph_we;
                slv_re    <= c0_rd;
            end else begin
                slv_sel   <= '0;
                slv_addr  <= '0;
                slv_wdata <= '0;
                slv_we    <= '0;
                slv_re    <= 1'b0;
            end
        end
    end

    assign c1_mapped   = 32'(c1_slot) < NSLV;
    assign c1_is_ic    = c1_slot == IC_SLOT;
    assign c1_unmapped = (c1_rd || c1_wr) && !c1_mapped && !c1_is_ic;

    assign ic_wr   = c1_wr && c1_is_ic;
    assign wr_pend = ic_wr && (c1_off == OFF_PEND);
    assign wr_en   = ic_wr && (c1_off == OFF_EN);
    assign wr_mode = ic_wr && (c1_off == OFF_MODE);
    assign wr_ucnt = ic_wr && (c1_off == OFF_UCNT);

    assign byte_mask = {{8{c1_we[3]}}, {8{c1_we[2]}}, {8{c1_we[1]}}, {8{c1_we[0]}}};
    assign wmask     = byte_mask[NIRQ-1:0];
    assign wbits     = c1_wdata[NIRQ-1:0];

    assign unused_bits = ^{dl1c2periph_addr, c1_wdata, byte_mask};

    always_comb begin
        slave_rdata = '0;
        for (int s = 0; s < NSLV; s++) begin
            if (c1_slot == SEL_W'(s)) slave_rdata = slv_rdata[s*32 +: 32];
        end
    end

    always_comb begin
        ic_rdata = '0;
        case (c1_off)
            OFF_PEND: ic_rdata = 32'(pend);
            OFF_EN:   ic_rdata = 32'(enable_r);
            OFF_MODE: ic_rdata = 32'(mode_r);
            OFF_RAW:  ic_rdata = 32'(irq_q);
            OFF_UCNT: ic_rdata = 32'(ucnt);
            default:  ic_rdata = '0;
        endcase
    end

    // Return stage: the read result is held until the next read completes.
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            dl1c2periph_data_in <= '0;
        end else if (c1_rd) begin
            if (c1_mapped)     dl1c2periph_data_in <= slave_rdata;
            else if (c1_is_ic) dl1c2periph_data_in <= ic_rdata;
            else               dl1c2periph_data_in <= '0;
        end
    end

    // Level lines mirror irq_q directly; only edge lines keep sticky state in pend_r.
    assign pend     = (pend_r & mode_r) | (irq_q & ~mode_r);
    assign edge_set = irq_src & ~irq_q & mode_r;
    assign w1c      = wr_pend ? (wbits & wmask & mode_r) : '0;
    assign req      = pend & enable_r;

    always_comb begin
        ack_clr = '0;
        if (state == ST_ASSERT && int_clear) begin
            for (int i = 0; i < NIRQ; i++) begin
                if (int_type == 4'(i)) ack_clr[i] = mode_r[i];
            end
        end
    end

    always_comb begin
        lowest = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) lowest = 4'(i);
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            irq_q    <= '0;
            pend_r   <= '0;
            enable_r <= '0;
            mode_r   <= '0;
            ucnt     <= '0;
        end else begin
            irq_q  <= irq_src;
            pend_r <= ((pend_r & ~(w1c | ack_clr)) | edge_set) & mode_r;
            if (wr_en)   enable_r <= (enable_r & ~wmask) | (wbits & wmask);
            if (wr_mode) mode_r   <= (mode_r & ~wmask) | (wbits & wmask);
            if (wr_ucnt)
                ucnt <= c1_unmapped ? 16'd1 : 16'd0;
            else if (c1_unmapped && ucnt != 16'hFFFF)
                ucnt <= ucnt + 16'd1;
        end
    end

    // The ACK cycle doubles as the arbitration point so the request gap is one cycle.
    always_comb begin
        state_next = state;
        type_next  = int_type;
        case (state)
            ST_IDLE, ST_ACK: begin
                if (|req) begin
                    state_next = ST_ASSERT;
                    type_next  = lowest;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ASSERT: if (int_clear) state_next = ST_ACK;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state    <= ST_IDLE;
            int_type <= '0;
        end else begin
            state    <= state_next;
            int_type <= type_next;
        end
    end

    assign int_pending = (state == ST_ASSERT);

endmodule

// File: tb/tb_mcpu_periph_fabric.sv
// Directed bench for mcpu_periph_fabric: a vector table for single transactions
// plus hand-written sequences for pipelining, saturation, interrupts and reset.
module tb_mcpu_periph_fabric;

    logic         clk = 1'b0;
    logic         rst;
    logic [29:0]  addr;
    logic [31:0]  wdata;
    logic         re;
    logic [3:0]   we;
    logic [31:0]  data_in;
    logic [3:0]   slv_sel;
    logic [9:0]   slv_addr;
    logic [31:0]  slv_wdata;
    logic [3:0]   slv_we;
    logic         slv_re;
    logic [127:0] slv_rdata;
    logic [7:0]   irq_src;
    logic         int_pending;
    logic [3:0]   int_type;
    logic         int_clear;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [127:0] RD_BASE = {32'hBAD00003, 32'hBAD00002, 32'hBAD00001, 32'hBAD00000};

    always #5 clk = ~clk;

    mcpu_periph_fabric dut (
        .clkrst_core_clk      (clk),
        .clkrst_core_rst      (rst),
        .dl1c2periph_addr     (addr),
        .dl1c2periph_data_out (wdata),
        .dl1c2periph_re       (re),
        .dl1c2periph_we       (we),
        .dl1c2periph_data_in  (data_in),
        .slv_sel              (slv_sel),
        .slv_addr             (slv_addr),
        .slv_wdata            (slv_wdata),
        .slv_we               (slv_we),
        .slv_re               (slv_re),
        .slv_rdata            (slv_rdata),
        .irq_src              (irq_src),
        .int_pending          (int_pending),
        .int_type             (int_type),
        .int_clear            (int_clear)
    );

    typedef struct {
        string       name;
        logic [3:0]  slot;
        logic [9:0]  off;
        logic        re;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  exp_sel;
        logic        exp_re;
        logic [3:0]  exp_we;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One isolated transaction: C0 drive, C1 slave-side checks, C2 return check.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        slv_rdata = RD_BASE;
        if (v.slot < 4) slv_rdata[v.slot*32 +: 32] = v.rdata;
        addr  = {16'h0, v.slot, v.off};
        re    = v.re;
        we    = v.we;
        wdata = v.wdata;
        @(negedge clk);
        re = 1'b0;
        we = 4'h0;
        checkOutput({v.name, ".sel"}, 32'(slv_sel), 32'(v.exp_sel));
        checkOutput({v.name, ".re"}, 32'(slv_re), 32'(v.exp_re));
        checkOutput({v.name, ".we"}, 32'(slv_we), 32'(v.exp_we));
        checkOutput({v.name, ".addr"}, 32'(slv_addr), (v.exp_sel != 0) ? 32'(v.off) : 32'h0);
        if (v.exp_we != 0) checkOutput({v.name, ".wdata"}, slv_wdata, v.wdata);
        @(negedge clk);
        checkOutput({v.name, ".din"}, data_in, v.exp_din);
    endtask

    task automatic bus_access(input logic [3:0] slot, input logic [9:0] off, input logic rd,
                              input logic [3:0] wen, input logic [31:0] data);
        @(negedge clk);
        addr  = {16'h0, slot, off};
        re    = rd;
        we    = wen;
        wdata = data;
        @(negedge clk);
        re = 1'b0;
        we = 4'h0;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] slot, input logic [9:0] off, input logic [3:0] wen,
                             input logic [31:0] data);
        bus_access(slot, off, 1'b0, wen, data);
    endtask

    task automatic bus_read_check(input string name, input logic [3:0] slot, input logic [9:0] off,
                                  input logic [31:0] exp);
        bus_access(slot, off, 1'b1, 4'h0, 32'h0);
        checkOutput(name, data_in, exp);
    endtask

    task automatic wait_pending(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (int_pending) break;
            @(negedge clk);
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        int_clear = 1'b1;
        @(negedge clk);
        int_clear = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"rd_s2_o5",   4'd2,  10'd5,   1'b1, 4'h0, 32'h0,        32'hCAFE0005, 4'b0100, 1'b1, 4'h0, 32'hCAFE0005};
        vecs[1]  = '{"wr_s1",      4'd1,  10'd3,   1'b0, 4'hF, 32'h12345678, 32'h0,        4'b0010, 1'b0, 4'hF, 32'hCAFE0005};
        vecs[2]  = '{"rdwr_s0",    4'd0,  10'd1,   1'b1, 4'h3, 32'h0000A5A5, 32'h11111111, 4'b0001, 1'b0, 4'h3, 32'hCAFE0005};
        vecs[3]  = '{"rd_s3",      4'd3,  10'h3FF, 1'b1, 4'h0, 32'h0,        32'hDEADBEEF, 4'b1000, 1'b1, 4'h0, 32'hDEADBEEF};
        vecs[4]  = '{"rd_s0",      4'd0,  10'd0,   1'b1, 4'h0, 32'h0,        32'h00000001, 4'b0001, 1'b1, 4'h0, 32'h00000001};
        vecs[5]  = '{"rd_unmap7",  4'd7,  10'd0,   1'b1, 4'h0, 32'h0,        32'h0,        4'b0000, 1'b0, 4'h0, 32'h0};
        vecs[6]  = '{"wr_unmap4",  4'd4,  10'd2,   1'b0, 4'h1, 32'h000000FF, 32'h0,        4'b0000, 1'b0, 4'h0, 32'h0};
        vecs[7]  = '{"rd_ucnt2",   4'd15, 10'd4,   1'b1, 4'h0, 32'h0,        32'h0,        4'b0000, 1'b0, 4'h0, 32'h2};
        vecs[8]  = '{"wr_ucnt",    4'd15, 10'd4,   1'b0, 4'h1, 32'h0,        32'h0,        4'b0000, 1'b0, 4'h0, 32'h2};
        vecs[9]  = '{"rd_ucnt0",   4'd15, 10'd4,   1'b1, 4'h0, 32'h0,        32'h0,        4'b0000, 1'b0, 4'h0, 32'h0};
        vecs[10] = '{"wr_en",      4'd15, 10'd1,   1'b0, 4'h1, 32'h000000A5, 32'h0,        4'b0000, 1'b0, 4'h0, 32'h0};
        vecs[11] = '{"rd_en",      4'd15, 10'd1,   1'b1, 4'h0, 32'h0,        32'h0,        4'b0000, 1'b0, 4'h0, 32'hA5};
        vecs[12] = '{"wr_en_b1",   4'd15, 10'd1,   1'b0, 4'h2, 32'hFFFFFF5A, 32'h0,        4'b0000, 1'b0, 4'h0, 32'hA5};
        vecs[13] = '{"rd_en_b1",   4'd15, 10'd1,   1'b1, 4'h0, 32'h0,        32'h0,        4'b0000, 1'b0, 4'h0, 32'hA5};
        vecs[14] = '{"wr_en_clr",  4'd15, 10'd1,   1'b0, 4'h1, 32'h0,        32'h0,        4'b0000, 1'b0, 4'h0, 32'hA5};
        vecs[15] = '{"rd_en_clr",  4'd15, 10'd1,   1'b1, 4'h0, 32'h0,        32'h0,        4'b0000, 1'b0, 4'h0, 32'h0};

        rst       = 1'b1;
        addr      = '0;
        wdata     = '0;
        re        = 1'b0;
        we        = 4'h0;
        slv_rdata = RD_BASE;
        irq_src   = '0;
        int_clear = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst.din", data_in, 32'h0);
        checkOutput("rst.sel", 32'(slv_sel), 32'h0);
        checkOutput("rst.slv_re", 32'(slv_re), 32'h0);
        checkOutput("rst.slv_we", 32'(slv_we), 32'h0);
        checkOutput("rst.int_pending", 32'(int_pending), 32'h0);
        checkOutput("rst.int_type", 32'(int_type), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

        // Back-to-back reads to slots 0, 1, 3 return in order.
        slv_rdata = {32'h40000003, 32'h30000002, 32'h20000001, 32'h10000000};
        @(negedge clk);
        addr = {16'h0, 4'd0, 10'd0}; re = 1'b1;
        @(negedge clk);
        checkOutput("b2b.sel0", 32'(slv_sel), 32'h1);
        addr = {16'h0, 4'd1, 10'd0};
        @(negedge clk);
        checkOutput("b2b.sel1", 32'(slv_sel), 32'h2);
        checkOutput("b2b.din0", data_in, 32'h10000000);
        addr = {16'h0, 4'd3, 10'd0};
        @(negedge clk);
        checkOutput("b2b.sel3", 32'(slv_sel), 32'h8);
        checkOutput("b2b.din1", data_in, 32'h20000001);
        re = 1'b0;
        @(negedge clk);
        checkOutput("b2b.sel_idle", 32'(slv_sel), 32'h0);
        checkOutput("b2b.din3", data_in, 32'h40000003);

        // Three unmapped reads in a row.
        bus_write(4'd15, 10'd4, 4'h1, 32'h0);
        @(negedge clk);
        addr = {16'h0, 4'd7, 10'd0}; re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("unmap.sel", 32'(slv_sel), 32'h0);
        end
        re = 1'b0;
        @(negedge clk);
        checkOutput("unmap.din", data_in, 32'h0);
        bus_read_check("unmap.ucnt3", 4'd15, 10'd4, 32'h3);
        bus_write(4'd15, 10'd4, 4'hF, 32'hFFFFFFFF);
        bus_read_check("unmap.ucnt_clr", 4'd15, 10'd4, 32'h0);

        // Saturation of the unmapped counter.
        @(negedge clk);
        addr = {16'h0, 4'd9, 10'd0}; re = 1'b1;
        for (int i = 0; i < 65535; i++) @(negedge clk);
        re = 1'b0;
        @(negedge clk);
        bus_read_check("sat.ucnt_max", 4'd15, 10'd4, 32'h0000FFFF);
        bus_access(4'd7, 10'd0, 1'b1, 4'h0, 32'h0);
        bus_read_check("sat.ucnt_hold", 4'd15, 10'd4, 32'h0000FFFF);

        // Edge interrupts on lines 3 and 2, enabled only after both have fired.
        bus_write(4'd15, 10'd2, 4'h1, 32'h0C);
        @(negedge clk); irq_src = 8'h08;
        @(negedge clk); irq_src = 8'h00;
        @(negedge clk); irq_src = 8'h04;
        @(negedge clk); irq_src = 8'h00;
        @(negedge clk);
        checkOutput("edge.no_enable", 32'(int_pending), 32'h0);
        bus_read_check("edge.pend", 4'd15, 10'd0, 32'h0C);
        bus_write(4'd15, 10'd1, 4'h1, 32'h0C);
        wait_pending(10);
        checkOutput("edge.pending", 32'(int_pending), 32'h1);
        checkOutput("edge.type2", 32'(int_type), 32'h2);
        ack_pulse();
        checkOutput("edge.gap", 32'(int_pending), 32'h0);
        @(negedge clk);
        checkOutput("edge.repend", 32'(int_pending), 32'h1);
        checkOutput("edge.type3", 32'(int_type), 32'h3);
        ack_pulse();
        checkOutput("edge.gap2", 32'(int_pending), 32'h0);
        @(negedge clk);
        checkOutput("edge.idle", 32'(int_pending), 32'h0);
        bus_read_check("edge.pend_clr", 4'd15, 10'd0, 32'h0);

        // Level interrupt on line 1.
        bus_write(4'd15, 10'd2, 4'h1, 32'h00);
        bus_write(4'd15, 10'd1, 4'h1, 32'h02);
        irq_src = 8'h02;
        wait_pending(10);
        checkOutput("lvl.pending", 32'(int_pending), 32'h1);
        checkOutput("lvl.type1", 32'(int_type), 32'h1);
        bus_read_check("lvl.raw", 4'd15, 10'd3, 32'h02);
        ack_pulse();
        checkOutput("lvl.gap", 32'(int_pending), 32'h0);
        @(negedge clk);
        checkOutput("lvl.reassert", 32'(int_pending), 32'h1);
        irq_src = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("lvl.withdrawn_held", 32'(int_pending), 32'h1);
        ack_pulse();
        checkOutput("lvl.gap2", 32'(int_pending), 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("lvl.stays_low", 32'(int_pending), 32'h0);

        // Edge on line 0 racing a W1C of the same bit.
        bus_write(4'd15, 10'd1, 4'h1, 32'h00);
        bus_write(4'd15, 10'd2, 4'h1, 32'h01);
        @(negedge clk); irq_src = 8'h01;
        @(negedge clk); irq_src = 8'h00;
        bus_read_check("race.pend_pre", 4'd15, 10'd0, 32'h01);
        @(negedge clk);
        addr = {16'h0, 4'd15, 10'd0}; we = 4'h1; wdata = 32'h01;
        @(negedge clk);
        we = 4'h0; irq_src = 8'h01;
        @(negedge clk);
        irq_src = 8'h00;
        @(negedge clk);
        bus_read_check("race.set_wins", 4'd15, 10'd0, 32'h01);
        bus_write(4'd15, 10'd0, 4'h1, 32'h01);
        bus_read_check("race.w1c_alone", 4'd15, 10'd0, 32'h00);

        // Reset while a read is in flight.
        slv_rdata = {32'h40000003, 32'h30000002, 32'h20000001, 32'h77777777};
        bus_read_check("rstmid.pre", 4'd1, 10'd0, 32'h20000001);
        @(negedge clk);
        addr = {16'h0, 4'd0, 10'd2}; re = 1'b1;
        @(negedge clk);
        checkOutput("rstmid.inflight", 32'(slv_sel), 32'h1);
        re = 1'b0; rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid.din", data_in, 32'h0);
        checkOutput("rstmid.sel", 32'(slv_sel), 32'h0);
        checkOutput("rstmid.slv_re", 32'(slv_re), 32'h0);
        checkOutput("rstmid.slv_addr", 32'(slv_addr), 32'h0);
        checkOutput("rstmid.int_pending", 32'(int_pending), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid.no_return", data_in, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
